// File: rtl/aes_job_scheduler_if.sv
// Requester-side bundle for aes_job_scheduler: two independent job ports,
// each with a request channel (valid/ready, mode, data, key) and a
// response channel (valid/ready, data, err).
//   master : the request sources (drive requests, consume responses)
//   slave  : the scheduler (accepts requests, produces responses)
interface aes_job_scheduler_if #(
  parameter int Nk = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_mode;
  logic [127:0]      req0_data;
  logic [Nk*32-1:0]  req0_key;
  logic              resp0_valid;
  logic              resp0_ready;
  logic [127:0]      resp0_data;
  logic              resp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_mode;
  logic [127:0]      req1_data;
  logic [Nk*32-1:0]  req1_key;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [127:0]      resp1_data;
  logic              resp1_err;

  modport master (
    output req0_valid, req0_mode, req0_data, req0_key, resp0_ready,
    output req1_valid, req1_mode, req1_data, req1_key, resp1_ready,
    input  req0_ready, resp0_valid, resp0_data, resp0_err,
    input  req1_ready, resp1_valid, resp1_data, resp1_err
  );

  modport slave (
    input  req0_valid, req0_mode, req0_data, req0_key, resp0_ready,
    input  req1_valid, req1_mode, req1_data, req1_key, resp1_ready,
    output req0_ready, resp0_valid, resp0_data, resp0_err,
    output req1_ready, resp1_valid, resp1_data, resp1_err
  );
endinterface

// File: rtl/aes_job_scheduler.sv
// Shares one AES SPI-master core between two requester ports.
// Round-robin arbitration, job latch, core reset pulse, timeout abort and
// per-port result delivery over valid/ready.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   host                requester bundle (slave side): req0/1, resp0/1
//   core_rst            active-high core reset, held high outside RUN
//   core_sel_encrypt/_decrypt  core mode selects from the latched job
//   core_data_in, core_key     latched job block and key
//   core_done, core_data_out   core completion and result
module aes_job_scheduler #(
  parameter int Nk             = 4,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              clk,
  input  logic              rst,
  aes_job_scheduler_if.slave host,
  output logic              core_rst,
  output logic              core_sel_encrypt,
  output logic              core_sel_decrypt,
  output logic [127:0]      core_data_in,
  output logic [Nk*32-1:0]  core_key,
  input  logic              core_done,
  input  logic [127:0]      core_data_out
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DELIVER} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          last_grant;

  logic          any_valid;
  logic          grant;
  logic          take;
  logic          take_mode;
  logic          resp_taken;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    any_valid = host.req0_valid | host.req1_valid;
    if (host.req0_valid && host.req1_valid) grant = ~last_grant;
    else                                    grant = host.req1_valid;
    take       = (state == IDLE) && any_valid;
    take_mode  = grant ? host.req1_mode : host.req0_mode;
    resp_taken = owner ? host.resp1_ready : host.resp0_ready;
  end

  assign host.req0_ready = take && !grant;
  assign host.req1_ready = take && grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      owner            <= 1'b0;
      last_grant       <= 1'b1;
      core_rst         <= 1'b1;
      core_sel_encrypt <= 1'b0;
      core_sel_decrypt <= 1'b0;
      core_data_in     <= '0;
      core_key         <= '0;
      host.resp0_valid <= 1'b0;
      host.resp0_data  <= '0;
      host.resp0_err   <= 1'b0;
      host.resp1_valid <= 1'b0;
      host.resp1_data  <= '0;
      host.resp1_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          core_rst <= 1'b1;
          if (take) begin
            owner            <= grant;
            last_grant       <= grant;
            core_data_in     <= grant ? host.req1_data : host.req0_data;
            core_key         <= grant ? host.req1_key  : host.req0_key;
            core_sel_encrypt <= !take_mode;
            core_sel_decrypt <= take_mode;
            cnt              <= '0;
            state            <= LAUNCH;
          end
        end
        // The counter starts at 0 on the accept edge and RUN is entered when
        // it reaches RST_CYCLES, so core_rst falls RST_CYCLES+1 edges after
        // the accept edge.
        LAUNCH: begin
          if (cnt == RST_LAST) begin
            core_rst <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // Done is tested first so a coincident timeout still returns data.
        RUN: begin
          if (core_done || cnt == TO_LAST) begin
            core_rst         <= 1'b1;
            core_sel_encrypt <= 1'b0;
            core_sel_decrypt <= 1'b0;
            cnt              <= '0;
            state            <= DELIVER;
            if (owner) begin
              host.resp1_valid <= 1'b1;
              host.resp1_data  <= core_done ? core_data_out : '0;
              host.resp1_err   <= !core_done;
            end else begin
              host.resp0_valid <= 1'b1;
              host.resp0_data  <= core_done ? core_data_out : '0;
              host.resp0_err   <= !core_done;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DELIVER: begin
          if (resp_taken) begin
            host.resp0_valid <= 1'b0;
            host.resp1_valid <= 1'b0;
            cnt              <= '0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Bench for aes_job_scheduler: behavioural AES core stand-in, accept-time
// scoreboard, table of jobs plus arbitration, timeout, back-pressure and
// mid-run reset sequences.
module tb_aes_job_scheduler;
  localparam int NK  = 4;
  localparam int KW  = NK * 32;
  localparam int RC  = 2;
  localparam int TO  = 16;
  localparam int LAT = 5;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [KW-1:0] K = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           core_rst, core_sel_encrypt, core_sel_decrypt;
  logic [127:0]   core_data_in;
  logic [KW-1:0]  core_key;
  logic           core_done = 1'b0;
  logic [127:0]   core_data_out = '0;

  aes_job_scheduler_if #(.Nk(NK)) bus();

  aes_job_scheduler #(.Nk(NK), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .host             (bus.slave),
    .core_rst         (core_rst),
    .core_sel_encrypt (core_sel_encrypt),
    .core_sel_decrypt (core_sel_decrypt),
    .core_data_in     (core_data_in),
    .core_key         (core_key),
    .core_done        (core_done),
    .core_data_out    (core_data_out)
  );

  // Stand-in for the AES core: knows the FIPS-197 vector pair, otherwise a
  // keyed scramble so results still depend on mode, data and key.
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] d,
                                           input logic [KW-1:0] k);
    if (k == K && !m && d == PT) return CT;
    if (k == K &&  m && d == CT) return PT;
    return d ^ k[127:0] ^ (m ? {4{32'hA5C3_0F96}} : {4{32'h5A3C_F069}});
  endfunction

  logic hang = 1'b0;
  int   core_cnt = 0;
  always @(negedge clk) begin
    if (core_rst) begin
      core_cnt  = 0;
      core_done = 1'b0;
    end else begin
      core_cnt++;
      if (core_cnt >= LAT && !hang) begin
        core_done     = 1'b1;
        core_data_out = core_fn(core_sel_decrypt, core_data_in, core_key);
      end
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  typedef struct {
    logic         port;
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  logic         grant_log[$];
  logic         last_port;
  logic [127:0] last_data;
  logic         last_err;
  bit           launching = 0;
  int           launch_hi = 0;
  int           run_lo = 0;
  logic         cur_mode = 1'b0;

  task automatic push_job(input logic p, input logic m, input logic [127:0] d,
                          input logic [KW-1:0] k);
    exp_t e;
    e.port = p;
    e.err  = hang;
    e.data = hang ? '0 : core_fn(m, d, k);
    sb.push_back(e);
    grant_log.push_back(p);
    cur_mode  = m;
    launching = 1;
    launch_hi = 0;
    run_lo    = 0;
  endtask

  task automatic pop_resp(input logic p, input logic [127:0] d, input logic er,
                          input logic other_valid);
    exp_t e;
    if (sb.size() == 0) begin
      fail_now("unexpected_resp");
    end else begin
      e = sb.pop_front();
      chk1("resp_port", p, e.port);
      chk("resp_data", d, e.data);
      chk1("resp_err", er, e.err);
      chk1("other_port_idle", other_valid, 1'b0);
      if (e.err) chk("timeout_run_cycles", 128'(run_lo), 128'(TO));
    end
    last_port = p;
    last_data = d;
    last_err  = er;
  endtask

  // Sampled on the falling edge: a valid&ready seen here completes on the
  // following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      launching = 0;
    end else begin
      if (launching) begin
        if (core_rst) launch_hi++;
        else begin
          chk("launch_latency", 128'(launch_hi), 128'(RC + 1));
          chk1("sel_encrypt", core_sel_encrypt, !cur_mode);
          chk1("sel_decrypt", core_sel_decrypt, cur_mode);
          launching = 0;
        end
      end
      if (!core_rst) run_lo++;
      if (bus.req0_ready && bus.req1_ready) fail_now("ready_onehot");
      if (bus.req0_valid && bus.req0_ready)
        push_job(1'b0, bus.req0_mode, bus.req0_data, bus.req0_key);
      else if (bus.req1_valid && bus.req1_ready)
        push_job(1'b1, bus.req1_mode, bus.req1_data, bus.req1_key);
      if (bus.resp0_valid && bus.resp0_ready)
        pop_resp(1'b0, bus.resp0_data, bus.resp0_err, bus.resp1_valid);
      if (bus.resp1_valid && bus.resp1_ready)
        pop_resp(1'b1, bus.resp1_data, bus.resp1_err, bus.resp0_valid);
    end
  end

  task automatic send(input logic p, input logic m, input logic [127:0] d,
                      input logic [KW-1:0] k);
    bit ok = 0;
    if (p) begin
      bus.req1_mode = m; bus.req1_data = d; bus.req1_key = k; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_mode = m; bus.req0_data = d; bus.req0_key = k; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = p ? bus.req1_ready : bus.req0_ready;
    end
    if (!ok) fail_now("accept_wait");
    @(posedge clk);
    #1;
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (sb.size() == 0);
    end
    if (!ok) fail_now("drain_wait");
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          port;
    logic          mode;
    logic [127:0]  data;
    logic [KW-1:0] key;
    logic [127:0]  exp_data;
    logic          exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    bit ok;
    logic [127:0] x1, x2;
    logic [KW-1:0] k2, k3;
    x1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    x2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    k2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    k3 = 128'hffeeddcc_bbaa9988_77665544_33221100;
    tbl[0] = '{1'b0, 1'b0, PT, K, CT, 1'b0};
    tbl[1] = '{1'b1, 1'b1, CT, K, PT, 1'b0};
    tbl[2] = '{1'b0, 1'b1, x1, k2, core_fn(1'b1, x1, k2), 1'b0};
    tbl[3] = '{1'b1, 1'b0, x2, k3, core_fn(1'b0, x2, k3), 1'b0};
    tbl[4] = '{1'b0, 1'b0, PT, k2, core_fn(1'b0, PT, k2), 1'b0};
    tbl[5] = '{1'b1, 1'b0, '1, '0, core_fn(1'b0, '1, '0), 1'b0};

    bus.req0_valid = 0; bus.req0_mode = 0; bus.req0_data = '0; bus.req0_key = '0;
    bus.req1_valid = 0; bus.req1_mode = 0; bus.req1_data = '0; bus.req1_key = '0;
    bus.resp0_ready = 1; bus.resp1_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_core_rst", core_rst, 1'b1);
    chk1("rst_sel_enc", core_sel_encrypt, 1'b0);
    chk1("rst_sel_dec", core_sel_decrypt, 1'b0);
    chk("rst_data_in", core_data_in, '0);
    chk("rst_key", core_key, '0);
    chk1("rst_resp0_valid", bus.resp0_valid, 1'b0);
    chk1("rst_resp1_valid", bus.resp1_valid, 1'b0);
    chk("rst_resp0_data", bus.resp0_data, '0);
    chk1("rst_resp0_err", bus.resp0_err, 1'b0);
    chk1("rst_req0_ready", bus.req0_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].port, tbl[i].mode, tbl[i].data, tbl[i].key);
      drain();
      chk1("tbl_port", last_port, tbl[i].port);
      chk("tbl_data", last_data, tbl[i].exp_data);
      chk1("tbl_err", last_err, tbl[i].exp_err);
    end

    // Both ports held valid: last winner was port 1, so 0,1,0,1 follows.
    grant_log.delete();
    bus.req0_mode = 0; bus.req0_data = x1; bus.req0_key = K;
    bus.req1_mode = 1; bus.req1_data = x2; bus.req1_key = k3;
    bus.req0_valid = 1; bus.req1_valid = 1;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (grant_log.size() >= 4);
    end
    if (!ok) fail_now("arb_wait");
    @(posedge clk);
    #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    drain();
    for (int i = 0; i < 4; i++) begin
      logic want;
      want = (i % 2 == 1);
      if (i < grant_log.size()) chk1("grant_order", grant_log[i], want);
    end

    // Core never finishes: abort after TO run cycles, then a normal job.
    hang = 1'b1;
    send(1'b0, 1'b0, PT, K);
    drain();
    chk1("timeout_err", last_err, 1'b1);
    chk("timeout_data", last_data, '0);
    hang = 1'b0;
    send(1'b0, 1'b0, PT, K);
    drain();
    chk("after_timeout_data", last_data, CT);
    chk1("after_timeout_err", last_err, 1'b0);

    // Response back-pressure with a competing port-1 request.
    bus.resp0_ready = 0;
    send(1'b0, 1'b1, x2, k2);
    bus.req1_mode = 0; bus.req1_data = x1; bus.req1_key = k3; bus.req1_valid = 1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.resp0_valid;
    end
    if (!ok) fail_now("bp_valid_wait");
    held = bus.resp0_data;
    chk("bp_first_data", held, core_fn(1'b1, x2, k2));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("bp_valid_held", bus.resp0_valid, 1'b1);
      chk("bp_data_stable", bus.resp0_data, held);
      chk1("bp_req1_ready", bus.req1_ready, 1'b0);
      chk1("bp_core_rst", core_rst, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.resp0_ready = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req1_ready;
    end
    if (!ok) fail_now("bp_req1_wait");
    @(posedge clk);
    #1;
    bus.req1_valid = 0;
    drain();
    chk1("bp_next_port", last_port, 1'b1);
    chk("bp_next_data", last_data, core_fn(1'b0, x1, k3));

    // Asynchronous reset in the middle of RUN discards the job.
    send(1'b0, 1'b0, PT, K);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = !core_rst;
    end
    if (!ok) fail_now("mid_rst_run_wait");
    #2;
    rst = 1'b0;
    #1;
    chk1("mid_rst_core_rst", core_rst, 1'b1);
    chk1("mid_rst_sel_enc", core_sel_encrypt, 1'b0);
    chk1("mid_rst_sel_dec", core_sel_decrypt, 1'b0);
    chk("mid_rst_data_in", core_data_in, '0);
    chk("mid_rst_key", core_key, '0);
    chk1("mid_rst_resp0_valid", bus.resp0_valid, 1'b0);
    chk1("mid_rst_resp1_valid", bus.resp1_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk1("post_rst_no_resp", bus.resp0_valid, 1'b0);
    chk1("post_rst_core_rst", core_rst, 1'b1);
    send(1'b0, 1'b0, PT, K);
    drain();
    chk("post_rst_data", last_data, CT);
    chk1("post_rst_port", last_port, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Shares one SPI_Master AES core between two requester ports (port 0, port 1). Each request carries a mode (encrypt/decrypt), a 128-bit data block and a key.
- Arbitrates between the ports round-robin and latches the job into the core.
- Restarts the core by pulsing the core reset, waits for done_out, and returns the result to the owning port over a valid/ready handshake.
- Sits between the system-side request sources and the AES SPI master; owns the core's reset and its select lines.

Parameters:
- Nk, 4, key length in 32-bit words; key width is Nk*32.
- RST_CYCLES, 2, cycles core_rst is held high before each job (minimum 1).
- TIMEOUT_CYCLES, 4095, maximum RUN cycles without core_done before the job is aborted.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 job request.
- req0_ready  out  1  port 0 job accepted (combinational).
- req0_mode  in  1  0 = encrypt, 1 = decrypt.
- req0_data  in  128  plaintext or ciphertext.
- req0_key  in  Nk*32  cipher key.
- resp0_valid  out  1  port 0 result available.
- resp0_ready  in  1  port 0 result consumed.
- resp0_data  out  128  result block.
- resp0_err  out  1  result is a timeout abort.
- req1_valid, req1_ready, req1_mode, req1_data, req1_key, resp1_valid, resp1_ready, resp1_data, resp1_err: same as port 0, for port 1.
- core_rst  out  1  active-high reset to the AES core.
- core_sel_encrypt  out  1  core encrypt select.
- core_sel_decrypt  out  1  core decrypt select.
- core_data_in  out  128  latched job data.
- core_key  out  Nk*32  latched job key.
- core_done  in  1  core done_out.
- core_data_out  in  128  core data_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, core_rst=1, core selects=0, core_data_in/core_key=0.
  - resp*_valid=0, resp*_data=0, resp*_err=0.
  - timeout counter=0; last_grant=1, so port 0 wins the first tie.
- Reset mid-operation: the job is discarded and no response is produced. After release, the block is in IDLE and the core is held in reset.
- States: IDLE, LAUNCH, RUN, DELIVER.
- IDLE:
  - core_rst=1.
  - grant = the only valid port; if both are valid, the port != last_grant.
  - reqN_ready = (state==IDLE) && grant==N; at most one ready is high at a time.
  - On valid&ready: latch data, key, mode and owner; set last_grant=owner; go to LAUNCH.
- LAUNCH:
  - core_rst=1 for exactly RST_CYCLES cycles (counter), then RUN.
  - Selects are driven from the latched mode throughout LAUNCH and RUN: mode 0 gives sel_encrypt=1, sel_decrypt=0; mode 1 gives sel_encrypt=0, sel_decrypt=1.
- RUN:
  - core_rst=0; the timeout counter increments each cycle.
  - If core_done=1: capture core_data_out, err=0, go to DELIVER.
  - Else if the counter reaches TIMEOUT_CYCLES-1: data=0, err=1, go to DELIVER.
  - If core_done coincides with the timeout, done wins (err=0).
- DELIVER:
  - core_rst=1 and selects=0.
  - respN_valid=1 for the owner only; respN_data and respN_err are held stable while valid.
  - On respN_ready: valid=0, counter=0, go to IDLE.
  - No new request is accepted until the response is taken; ready already high at DELIVER entry completes in one cycle.
- core_done outside RUN is ignored.
- Latency:
  - Accept edge T → core_rst falls at T+RST_CYCLES+1 → respN_valid rises 1 cycle after core_done is sampled.
  - Minimum back-to-back: the next request is accepted on the cycle after the response handshake.
- Request inputs may change while not ready; only the values present at the valid&ready edge are used.
- A port deasserting valid before ready is legal; the arbiter re-evaluates every IDLE cycle.

Test Plan:
- Port 0, mode 0, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, resp0_ready=1 → core_sel_encrypt=1, core_rst low for the run, resp0_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp0_err=0, resp1_valid never asserted.
- Port 1, mode 1, data 69c4e0d86a7b0430d8cdb78070b4c55a, same key → core_sel_decrypt=1, resp1_data=00112233445566778899aabbccddeeff.
- Both ports valid continuously, 4 jobs → grant order 0,1,0,1; each response appears only on the owning port.
- Core model never asserts done, TIMEOUT_CYCLES=16 → resp0_valid rises 16 RUN cycles after core_rst falls, resp0_err=1, resp0_data=0; the next job then completes normally.
- resp0_ready held 0 for 10 cycles after resp0_valid → data stable, req1_ready stays 0, no new core_rst low period; releasing ready returns to IDLE.
- rst driven low during RUN → all outputs at reset values immediately (asynchronously), core_rst=1, no response; a fresh job after release completes with the correct ciphertext.
